// File: rtl/ice_pin_walker.sv
// ice_pin_walker: walking-one/zero pin stimulus sequencer for the pico-ice jig.
// Ports: clk, rst_n, start, abort, mode -> pins_o, pins_oe, index, step, busy, done.
module ice_pin_walker #(
  parameter int NUM_PINS = 40,
  parameter int DWELL    = 12000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        mode,
  output logic [NUM_PINS-1:0]         pins_o,
  output logic [NUM_PINS-1:0]         pins_oe,
  output logic [$clog2(NUM_PINS)-1:0] index,
  output logic                        step,
  output logic                        busy,
  output logic                        done
);

  localparam int IW = $clog2(NUM_PINS);
  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_PINS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEAD,
    S_WALK,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic [NUM_PINS-1:0]  pins_q, pins_d;
  logic [NUM_PINS-1:0]  oe_q, oe_d;
  logic                 step_q, step_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [NUM_PINS-1:0]  walk_bit;
  logic [NUM_PINS-1:0]  inact;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LEAD;
            mode_d  = mode;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end
        S_LEAD: begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_WALK;
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WALK: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = S_DONE;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they leave the flops
  // aligned with the state they describe.
  always_comb begin
    walk_bit = NUM_PINS'(1) << idx_d;
    inact    = {NUM_PINS{mode_d}};
    pins_d   = '0;
    oe_d     = '0;
    step_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    unique case (1'b1)
      (state_d == S_LEAD): begin
        oe_d   = '1;
        pins_d = inact;
        busy_d = 1'b1;
      end
      (state_d == S_WALK): begin
        oe_d   = '1;
        pins_d = inact ^ walk_bit;
        busy_d = 1'b1;
        step_d = (state_q != S_WALK) || (idx_d != idx_q);
      end
      (state_d == S_DONE): begin
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      pins_q  <= '0;
      oe_q    <= '0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      pins_q  <= pins_d;
      oe_q    <= oe_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pins_o  = pins_q;
  assign pins_oe = oe_q;
  assign index   = idx_q;
  assign step    = step_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_ice_pin_walker.sv
// Testbench for ice_pin_walker: a 4-pin/dwell-3 and a 40-pin/dwell-1 instance
// checked against a cycle-count reference model, a vector table and corner sequences.
module tb_ice_pin_walker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic s4, a4, m4, s40, a40, m40;
  logic [3:0]  pins4, oe4;
  logic [1:0]  idx4;
  logic        step4, busy4, done4;
  logic [39:0] pins40, oe40;
  logic [5:0]  idx40;
  logic        step40, busy40, done40;

  ice_pin_walker #(.NUM_PINS(4), .DWELL(3)) u4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .abort(a4), .mode(m4),
    .pins_o(pins4), .pins_oe(oe4), .index(idx4),
    .step(step4), .busy(busy4), .done(done4)
  );

  ice_pin_walker #(.NUM_PINS(40), .DWELL(1)) u40 (
    .clk(clk), .rst_n(rst_n), .start(s40), .abort(a40), .mode(m40),
    .pins_o(pins40), .pins_oe(oe40), .index(idx40),
    .step(step40), .busy(busy40), .done(done40)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: cycles elapsed since the accepted start.
  bit run [2];
  int t   [2];
  bit mm  [2];
  int midx[2];

  function automatic int np(int i);
    return (i == 0) ? 4 : 40;
  endfunction

  function automatic int dw(int i);
    return (i == 0) ? 3 : 1;
  endfunction

  typedef struct {
    logic [63:0] pins;
    logic [63:0] oe;
    logic [63:0] idx;
    logic        step;
    logic        busy;
    logic        done;
  } exp_t;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      run[i] = 0; t[i] = 0; mm[i] = 0; midx[i] = 0;
    end
  endtask

  task automatic model_step(int i, logic s, logic a, logic m);
    int d = dw(i);
    int tot = (np(i) + 1) * d;
    if (a) run[i] = 0;
    else if (run[i]) begin
      if (t[i] == tot + 1) run[i] = 0;
      else begin
        t[i]++;
        if (t[i] > d && t[i] <= tot) midx[i] = (t[i] - 1) / d - 1;
      end
    end else if (s) begin
      run[i] = 1; t[i] = 1; mm[i] = m; midx[i] = 0;
    end
  endtask

  function automatic exp_t model_exp(int i);
    int n = np(i);
    int d = dw(i);
    int tot = (n + 1) * d;
    logic [63:0] mask = (64'd1 << n) - 64'd1;
    logic [63:0] oh;
    exp_t e;
    e.pins = '0; e.oe = '0; e.step = 0; e.busy = 0; e.done = 0;
    e.idx = 64'(midx[i]);
    if (run[i] && t[i] <= tot) begin
      e.busy = 1;
      e.oe = mask;
      if (t[i] <= d) e.pins = mm[i] ? mask : 64'd0;
      else begin
        oh = 64'd1 << midx[i];
        e.pins = mm[i] ? (mask ^ oh) : oh;
        e.step = ((t[i] - 1) % d) == 0;
      end
    end else if (run[i]) e.done = 1;
    return e;
  endfunction

  task automatic chk_inst(int i, logic [63:0] p, logic [63:0] o,
                          logic [63:0] x, logic st, logic b, logic dn);
    exp_t e = model_exp(i);
    chk($sformatf("u%0d.pins", i), p, e.pins);
    chk($sformatf("u%0d.oe", i), o, e.oe);
    chk($sformatf("u%0d.index", i), x, e.idx);
    chk($sformatf("u%0d.step", i), 64'(st), 64'(e.step));
    chk($sformatf("u%0d.busy", i), 64'(b), 64'(e.busy));
    chk($sformatf("u%0d.done", i), 64'(dn), 64'(e.done));
  endtask

  task automatic check_all();
    chk_inst(0, 64'(pins4), 64'(oe4), 64'(idx4), step4, busy4, done4);
    chk_inst(1, 64'(pins40), 64'(oe40), 64'(idx40), step40, busy40, done40);
  endtask

  // One clock: inputs stay stable over the edge, model advances, compare.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else begin
      model_step(0, s4, a4, m4);
      model_step(1, s40, a40, m40);
    end
    check_all();
  endtask

  typedef struct {
    logic       start;
    logic       abort;
    logic       mode;
    logic [3:0] pins;
    logic [3:0] oe;
    logic       step;
    logic       busy;
    logic       done;
    logic [1:0] idx;
  } vec_t;

  vec_t vec [17];

  int cnt_a, cnt_b, cnt_c, cyc;

  initial begin
    vec[0]  = '{1, 0, 0, 4'b0000, 4'hF, 0, 1, 0, 2'd0};
    vec[1]  = '{0, 0, 0, 4'b0000, 4'hF, 0, 1, 0, 2'd0};
    vec[2]  = '{0, 0, 0, 4'b0000, 4'hF, 0, 1, 0, 2'd0};
    vec[3]  = '{0, 0, 0, 4'b0001, 4'hF, 1, 1, 0, 2'd0};
    vec[4]  = '{0, 0, 0, 4'b0001, 4'hF, 0, 1, 0, 2'd0};
    vec[5]  = '{0, 0, 1, 4'b0001, 4'hF, 0, 1, 0, 2'd0};
    vec[6]  = '{0, 0, 1, 4'b0010, 4'hF, 1, 1, 0, 2'd1};
    vec[7]  = '{1, 0, 1, 4'b0010, 4'hF, 0, 1, 0, 2'd1};
    vec[8]  = '{0, 0, 0, 4'b0010, 4'hF, 0, 1, 0, 2'd1};
    vec[9]  = '{0, 0, 0, 4'b0100, 4'hF, 1, 1, 0, 2'd2};
    vec[10] = '{0, 0, 0, 4'b0100, 4'hF, 0, 1, 0, 2'd2};
    vec[11] = '{0, 0, 0, 4'b0100, 4'hF, 0, 1, 0, 2'd2};
    vec[12] = '{0, 0, 0, 4'b1000, 4'hF, 1, 1, 0, 2'd3};
    vec[13] = '{0, 0, 0, 4'b1000, 4'hF, 0, 1, 0, 2'd3};
    vec[14] = '{0, 0, 0, 4'b1000, 4'hF, 0, 1, 0, 2'd3};
    vec[15] = '{0, 0, 0, 4'b0000, 4'h0, 0, 0, 1, 2'd3};
    vec[16] = '{0, 0, 0, 4'b0000, 4'h0, 0, 0, 0, 2'd3};

    rst_n = 1'b0;
    s4 = 0; a4 = 0; m4 = 0; s40 = 0; a40 = 0; m40 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    repeat (2) tick();

    // Walking one, table-driven; includes mid-walk mode toggle and start.
    for (int r = 0; r < 17; r++) begin
      s4 = vec[r].start; a4 = vec[r].abort; m4 = vec[r].mode;
      tick();
      chk($sformatf("tbl%0d.pins", r), 64'(pins4), 64'(vec[r].pins));
      chk($sformatf("tbl%0d.oe", r), 64'(oe4), 64'(vec[r].oe));
      chk($sformatf("tbl%0d.step", r), 64'(step4), 64'(vec[r].step));
      chk($sformatf("tbl%0d.busy", r), 64'(busy4), 64'(vec[r].busy));
      chk($sformatf("tbl%0d.done", r), 64'(done4), 64'(vec[r].done));
      chk($sformatf("tbl%0d.idx", r), 64'(idx4), 64'(vec[r].idx));
    end
    s4 = 0; m4 = 0;
    tick();

    // Walking zero with mode toggled every cycle after start.
    s4 = 1; m4 = 1;
    tick();
    chk("wz.lead", 64'(pins4), 64'hF);
    s4 = 0;
    for (int c = 2; c <= 17; c++) begin
      m4 = ~m4;
      tick();
      if (c == 4)  chk("wz.idx0", 64'(pins4), 64'hE);
      if (c == 7)  chk("wz.idx1", 64'(pins4), 64'hD);
      if (c == 10) chk("wz.idx2", 64'(pins4), 64'hB);
      if (c == 13) chk("wz.idx3", 64'(pins4), 64'h7);
      if (c == 16) chk("wz.done", 64'(done4), 64'd1);
    end
    m4 = 0;

    // Abort at index 1, then restart.
    s4 = 1;
    tick();
    s4 = 0;
    repeat (6) tick();
    chk("ab.idx1", 64'(idx4), 64'd1);
    a4 = 1;
    tick();
    a4 = 0;
    chk("ab.oe", 64'(oe4), 64'd0);
    chk("ab.busy", 64'(busy4), 64'd0);
    cnt_a = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done4) cnt_a++;
    end
    chk("ab.nodone", 64'(cnt_a), 64'd0);
    s4 = 1;
    tick();
    s4 = 0;
    chk("ab.restart_busy", 64'(busy4), 64'd1);
    chk("ab.restart_idx", 64'(idx4), 64'd0);
    repeat (17) tick();

    // Start and abort together in IDLE.
    s4 = 1; a4 = 1;
    tick();
    chk("sa.busy", 64'(busy4), 64'd0);
    s4 = 0; a4 = 0;
    repeat (2) tick();
    chk("sa.idle", 64'(busy4), 64'd0);

    // Reset in WALK at index 2.
    s4 = 1;
    tick();
    s4 = 0;
    repeat (9) tick();
    chk("rst.pre_idx", 64'(idx4), 64'd2);
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst.oe", 64'(oe4), 64'd0);
    chk("rst.idx", 64'(idx4), 64'd0);
    chk("rst.busy", 64'(busy4), 64'd0);
    chk("rst.pins", 64'(pins4), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("rst.quiet", 64'(busy4), 64'd0);

    // DWELL=1, 40 pins.
    s40 = 1; m40 = 0;
    tick();
    s40 = 0;
    cnt_a = busy40 ? 1 : 0;
    cnt_b = 0; cnt_c = 0; cyc = 0;
    for (int c = 2; c <= 46; c++) begin
      tick();
      if (busy40) cnt_a++;
      if (step40) begin
        cnt_b++;
        if (int'(idx40) != c - 2) cnt_c++;
      end
      if (done40) cyc = c;
    end
    chk("d1.busy_cycles", 64'(cnt_a), 64'd41);
    chk("d1.steps", 64'(cnt_b), 64'd40);
    chk("d1.idx_gaps", 64'(cnt_c), 64'd0);
    chk("d1.done_cycle", 64'(cyc), 64'd42);

    // Randomised traffic on both instances against the model.
    for (int c = 0; c < 4000; c++) begin
      s4  = ($urandom_range(0, 7) == 0);
      a4  = ($urandom_range(0, 63) == 0);
      m4  = 1'($urandom);
      s40 = ($urandom_range(0, 7) == 0);
      a40 = ($urandom_range(0, 63) == 0);
      m40 = 1'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
